alu4_acc: RTL and testbench

ALU4_ACC -- requirements
Module: alu4_acc

---
 rtl/alu4_pkg.sv | 23 ++
 rtl/alu4.sv | 52 +++++
 rtl/alu4_acc.sv | 116 +++++++++++
 tb/tb_alu4_acc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - shared opcode and FSM state encodings for alu4 and alu4_acc
package alu4_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [2:0] {
        OP_NOTA = 3'b000,
        OP_NOTB = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ADD  = 3'b110,
        OP_SUB  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/alu4.sv
// rtl/alu4.sv - combinational 4-bit ALU with carry, negative, zero, overflow flags
// Ports: i_op opcode; i_a/i_b operands; o_result; o_c/o_n/o_z/o_v flags.
module alu4
    import alu4_pkg::*;
(
    input  alu_op_e             i_op,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [DATA_W-1:0]   o_result,
    output logic                o_c,
    output logic                o_n,
    output logic                o_z,
    output logic                o_v
);

    logic [DATA_W:0] w_sum;

    always_comb begin
        w_sum    = '0;
        o_result = '0;
        o_c      = 1'b0;
        o_v      = 1'b0;
        case (i_op)
            OP_NOTA: o_result = ~i_a;
            OP_NOTB: o_result = ~i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_XNOR: o_result = ~(i_a ^ i_b);
            OP_ADD: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[DATA_W-1:0];
                o_c      = w_sum[DATA_W];
                o_v      = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != i_a[DATA_W-1]);
            end
            OP_SUB: begin
                // a + ~b + 1: carry-out of 1 means no borrow
                w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;
                o_result = w_sum[DATA_W-1:0];
                o_c      = w_sum[DATA_W];
                o_v      = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != i_a[DATA_W-1]);
            end
            default: o_result = '0;
        endcase
    end

    assign o_n = o_result[DATA_W-1];
    assign o_z = (o_result == '0);

endmodule

// File: rtl/alu4_acc.sv
// rtl/alu4_acc.sv - handshaked 4-bit ALU with accumulator and sticky overflow
// Ports: clk, reset (async high); in_valid/in_ready/in_op/in_a/in_b/use_acc request side;
// acc_clr; out_valid/out_ready/out_result/out_c/out_n/out_z/out_v result side; acc, v_sticky.
module alu4_acc
    import alu4_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    input  logic                use_acc,
    input  logic                acc_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_result,
    output logic                out_c,
    output logic                out_n,
    output logic                out_z,
    output logic                out_v,
    output logic [DATA_W-1:0]   acc,
    output logic                v_sticky
);

    state_e              r_state;
    alu_op_e             r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_result;
    logic                r_c;
    logic                r_n;
    logic                r_z;
    logic                r_v;
    logic                r_v_sticky;

    logic                w_accept;
    logic [DATA_W-1:0]   w_alu_result;
    logic                w_alu_c;
    logic                w_alu_n;
    logic                w_alu_z;
    logic                w_alu_v;

    alu4 u_alu4 (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_c      (w_alu_c),
        .o_n      (w_alu_n),
        .o_z      (w_alu_z),
        .o_v      (w_alu_v)
    );

    // HOLD can take a new request on the same edge the current result retires
    assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_NOTA;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_c        <= 1'b0;
            r_n        <= 1'b0;
            r_z        <= 1'b0;
            r_v        <= 1'b0;
            r_v_sticky <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) r_state <= ST_EXEC;
                ST_EXEC: begin
                    r_state  <= ST_HOLD;
                    r_result <= w_alu_result;
                    r_c      <= w_alu_c;
                    r_n      <= w_alu_n;
                    r_z      <= w_alu_z;
                    r_v      <= w_alu_v;
                end
                ST_HOLD: if (out_ready) r_state <= w_accept ? ST_EXEC : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            // Operand capture reads the pre-clear accumulator even when acc_clr is high
            if (w_accept) begin
                r_op <= alu_op_e'(in_op);
                r_a  <= use_acc ? r_acc : in_a;
                r_b  <= in_b;
            end

            // Clear takes priority over the EXEC write-back
            if (acc_clr) begin
                r_acc      <= '0;
                r_v_sticky <= 1'b0;
            end else if (r_state == ST_EXEC) begin
                r_acc      <= w_alu_result;
                r_v_sticky <= r_v_sticky | w_alu_v;
            end
        end
    end

    assign out_valid  = (r_state == ST_HOLD);
    assign out_result = r_result;
    assign out_c      = r_c;
    assign out_n      = r_n;
    assign out_z      = r_z;
    assign out_v      = r_v;
    assign acc        = r_acc;
    assign v_sticky   = r_v_sticky;

endmodule

// File: tb/tb_alu4_acc.sv
// tb/tb_alu4_acc.sv - directed self-checking bench for alu4_acc
module tb_alu4_acc;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       use_acc;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_c;
    logic       out_n;
    logic       out_z;
    logic       out_v;
    logic [3:0] acc;
    logic       v_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    alu4_acc dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .use_acc    (use_acc),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_c      (out_c),
        .out_n      (out_n),
        .out_z      (out_z),
        .out_v      (out_v),
        .acc        (acc),
        .v_sticky   (v_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        use_acc  = ua;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] r, input logic c, input logic n,
                           input logic z, input logic v);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_res"}, out_result, r);
        chk({tag, "_flags"}, {out_c, out_n, out_z, out_v}, {c, n, z, v});
    endtask

    // Issue, confirm no early valid during EXEC, then land in HOLD
    task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic ua);
        issue(op, a, b, ua);
        chk({tag, "_exec_valid"}, out_valid, 1'b0);
        tick();
    endtask

    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("retire_valid", out_valid, 1'b0);
        chk("retire_ready", in_ready, 1'b1);
    endtask

    // op, a, b, expected result, c, n, z, v
    logic [2:0] t_op  [6] = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b111, 3'b110};
    logic [3:0] t_a   [6] = '{4'h0,   4'h9,   4'hC,   4'hC,   4'h3,   4'hF};
    logic [3:0] t_b   [6] = '{4'h5,   4'h4,   4'hA,   4'hA,   4'h5,   4'h1};
    logic [3:0] t_r   [6] = '{4'hA,   4'hD,   4'h6,   4'h9,   4'hE,   4'h0};
    logic [3:0] t_cnzv[6] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b1010};

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_acc", acc, 4'h0);
        chk("rst_flags", {out_c, out_n, out_z, out_v, v_sticky}, 5'b0);

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("tbl%0d", i), t_op[i], t_a[i], t_b[i], 1'b0);
            chk_out($sformatf("tbl%0d", i), t_r[i], t_cnzv[i][3], t_cnzv[i][2], t_cnzv[i][1], t_cnzv[i][0]);
            chk($sformatf("tbl%0d_acc", i), acc, t_r[i]);
            retire();
        end

        // ADD 5+3 then accumulator chain
        run_op("add", 3'b110, 4'h5, 4'h3, 1'b0);
        chk_out("add", 4'h8, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("add_acc", acc, 4'h8);
        chk("add_vs", v_sticky, 1'b1);
        chk("add_hold_ready", in_ready, 1'b0);
        retire();
        run_op("sub", 3'b111, 4'h0, 4'h1, 1'b1);
        chk_out("sub", 4'h7, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sub_acc", acc, 4'h7);
        retire();
        run_op("and", 3'b010, 4'hF, 4'h0, 1'b1);
        chk_out("and", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("and_acc", acc, 4'h0);
        chk("and_vs", v_sticky, 1'b1);

        // Backpressure: request pending while HOLD stalls
        in_op = 3'b110; in_a = 4'h2; in_b = 4'h3; use_acc = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_ready", in_ready, 1'b0);
            chk("bp_res", out_result, 4'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_exec_valid", out_valid, 1'b0);
        tick();
        chk_out("bp_add", 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_acc", acc, 4'h5);

        // acc_clr during HOLD
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("clr_hold_acc", acc, 4'h0);
        chk("clr_hold_vs", v_sticky, 1'b0);
        chk_out("clr_hold", 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);

        // acc_clr coincident with EXEC end
        in_op = 3'b110; in_a = 4'h7; in_b = 4'h1; use_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b1;
        chk("clr_exec_exec_valid", out_valid, 1'b0);
        tick();
        acc_clr = 1'b0;
        chk_out("clr_exec", 4'h8, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_exec_acc", acc, 4'h0);
        chk("clr_exec_vs", v_sticky, 1'b0);

        // acc_clr coincident with use_acc accept: capture pre-clear acc
        in_op = 3'b110; in_a = 4'h6; in_b = 4'h0; use_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("pre_acc", acc, 4'h6);
        in_op = 3'b110; in_a = 4'h0; in_b = 4'h1; use_acc = 1'b1; in_valid = 1'b1; out_ready = 1'b1; acc_clr = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
        chk("capclr_acc_cleared", acc, 4'h0);
        tick();
        chk_out("capclr", 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("capclr_acc", acc, 4'h7);
        retire();

        // Reset mid-cycle during EXEC of NOT A
        issue(3'b000, 4'h0, 4'h0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ready", in_ready, 1'b1);
        chk("arst_acc", acc, 4'h0);
        chk("arst_res", out_result, 4'h0);
        chk("arst_flags", {out_c, out_n, out_z, out_v, v_sticky}, 5'b0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_no_pulse", out_valid, 1'b0);
        end
        chk("arst_res_after", out_result, 4'h0);
        run_op("add2", 3'b110, 4'h5, 4'h3, 1'b0);
        chk_out("add2", 4'h8, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("add2_acc", acc, 4'h8);
        chk("add2_vs", v_sticky, 1'b1);
        retire();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
